// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: a zero-wait-state bus responder feeding
// a circular TX FIFO that a baud-rate FSM drains onto the serial line.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  input  logic        mem_write,
  output logic [31:0] read_data,
  output logic        sel,
  output logic        tx
);

  localparam int unsigned   PW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned   CW       = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  // Bus decode
  logic        w_sel;
  logic [1:0]  w_idx;
  logic        w_wr;
  logic        w_push_req;
  logic        w_push;
  logic        w_pop;
  logic        w_full;
  logic        w_empty;
  logic        w_busy;
  logic [3:0]  w_cnt4;
  logic [31:0] w_status;
  logic [31:0] w_rdata;
  logic [7:0]  w_head;
  logic        w_unused;

  // FIFO and configuration state
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_ovf;
  logic [15:0]   r_bauddiv;

  // Transmitter state
  state_t      r_state;
  state_t      w_state_next;
  logic [15:0] r_baud_cnt;
  logic [15:0] w_baud_next;
  logic [2:0]  r_bit_cnt;
  logic [2:0]  w_bit_next;
  logic [7:0]  r_shift;
  logic [7:0]  w_shift_next;
  logic [15:0] r_div;
  logic [15:0] w_div_next;
  logic        w_baud_last;
  logic        r_tx;
  logic        w_tx_next;

  assign w_sel      = (addr[31:4] == BASE_ADDR[31:4]);
  assign w_idx      = addr[3:2];
  assign w_wr       = w_sel && mem_write;
  assign w_push_req = w_wr && (w_idx == 2'd0);
  assign w_full     = (r_count == FULL_CNT);
  assign w_empty    = (r_count == '0);
  assign w_push     = w_push_req && !w_full;
  assign w_head     = r_mem[r_rptr];
  assign w_busy     = (r_state != S_IDLE);
  assign w_cnt4     = 4'(r_count);
  assign w_status   = {24'd0, w_cnt4, r_ovf, w_busy, w_empty, w_full};

  // Byte-lane address bits and upper store bits carry no meaning here.
  assign w_unused = &{1'b0, addr[1:0], write_data[31:16]};

  always_comb begin
    w_rdata = '0;
    if (w_sel) begin
      case (w_idx)
        2'd1:    w_rdata = w_status;
        2'd2:    w_rdata = {16'd0, r_bauddiv};
        default: w_rdata = '0;
      endcase
    end
  end

  assign read_data = w_rdata;
  assign sel       = w_sel;
  assign tx        = r_tx;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= write_data[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_ovf     <= 1'b0;
      r_bauddiv <= DEFAULT_DIV;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      // A rejected push wins over a clear; both cannot share a cycle anyway.
      if (w_push_req && w_full) begin
        r_ovf <= 1'b1;
      end else if (w_wr && (w_idx == 2'd1) && write_data[3]) begin
        r_ovf <= 1'b0;
      end
      if (w_wr && (w_idx == 2'd2)) begin
        r_bauddiv <= (write_data[15:0] == 16'd0) ? 16'd1 : write_data[15:0];
      end
    end
  end

  assign w_baud_last = (r_baud_cnt == (r_div - 16'd1));

  always_comb begin
    w_state_next = r_state;
    w_baud_next  = r_baud_cnt;
    w_bit_next   = r_bit_cnt;
    w_shift_next = r_shift;
    w_div_next   = r_div;
    w_pop        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_shift_next = w_head;
          w_div_next   = r_bauddiv;
          w_baud_next  = '0;
          w_state_next = S_START;
        end
      end
      S_START: begin
        if (w_baud_last) begin
          w_baud_next  = '0;
          w_bit_next   = '0;
          w_state_next = S_DATA;
        end else begin
          w_baud_next = r_baud_cnt + 16'd1;
        end
      end
      S_DATA: begin
        if (w_baud_last) begin
          w_baud_next  = '0;
          w_shift_next = {1'b0, r_shift[7:1]};
          if (r_bit_cnt == 3'd7) begin
            w_state_next = S_STOP;
          end else begin
            w_bit_next = r_bit_cnt + 3'd1;
          end
        end else begin
          w_baud_next = r_baud_cnt + 16'd1;
        end
      end
      S_STOP: begin
        if (w_baud_last) begin
          w_baud_next = '0;
          // Chain straight into the next start bit when a byte is waiting.
          if (!w_empty) begin
            w_pop        = 1'b1;
            w_shift_next = w_head;
            w_div_next   = r_bauddiv;
            w_state_next = S_START;
          end else begin
            w_state_next = S_IDLE;
          end
        end else begin
          w_baud_next = r_baud_cnt + 16'd1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase

    case (w_state_next)
      S_START: w_tx_next = 1'b0;
      S_DATA:  w_tx_next = w_shift_next[0];
      default: w_tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_div      <= DEFAULT_DIV;
      r_tx       <= 1'b1;
    end else begin
      r_state    <= w_state_next;
      r_baud_cnt <= w_baud_next;
      r_bit_cnt  <= w_bit_next;
      r_shift    <= w_shift_next;
      r_div      <= w_div_next;
      r_tx       <= w_tx_next;
    end
  end

endmodule
